// File: rtl/axis_ascon_aead128_stimgen.sv
// -----------------------------------------------------------------------------
// axis_ascon_aead128_stimgen
//
// Generates one Ascon-AEAD128 job per accepted config request. Each job is a
// single command beat carrying key, nonce and the encrypt flag. It is followed
// by the associated-data beats and then the payload beats. The data pattern
// comes from a 32-bit Galois LFSR. The LFSR advances once per accepted master
// beat, so every beat carries fresh data.
//
// Ports
//   clk, resetn                     clock, asynchronous active-low reset
//   s_cfg_tvalid / s_cfg_tready     job request handshake (ready only in IDLE)
//   s_cfg_ad_bytes, s_cfg_d_bytes   AD / payload length in bytes
//   s_cfg_encrypt                   encrypt flag, placed in cmd bit 256
//   m_cmd_*                         512-bit command stream
//   m_ad_*                          128-bit AD stream with tlast/tkeep
//   m_*                             128-bit payload stream with tlast/tkeep
//   done                            one-cycle pulse after a job's last transfer
//   busy                            high whenever the FSM is not IDLE
//   dbg_state_o                     current FSM state, for observation
//
// Handshake rule for every stream: a transfer happens on a rising edge where
// tvalid and tready are both high. Once tvalid rises, tvalid and all payload
// signals stay unchanged until that transfer. At most one master tvalid is
// high at any time.
// -----------------------------------------------------------------------------
module axis_ascon_aead128_stimgen #(
   parameter logic [31:0] lfsr_seed   = 32'hACE1_1234,
   parameter int          max_bytes_w = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   s_cfg_tvalid,
   output logic                   s_cfg_tready,
   input  logic [max_bytes_w-1:0] s_cfg_ad_bytes,
   input  logic [max_bytes_w-1:0] s_cfg_d_bytes,
   input  logic                   s_cfg_encrypt,
   output logic                   m_cmd_tvalid,
   input  logic                   m_cmd_tready,
   output logic [511:0]           m_cmd_tdata,
   output logic                   m_ad_tvalid,
   input  logic                   m_ad_tready,
   output logic                   m_ad_tlast,
   output logic [127:0]           m_ad_tdata,
   output logic [15:0]            m_ad_tkeep,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tlast,
   output logic [127:0]           m_tdata,
   output logic [15:0]            m_tkeep,
   output logic                   done,
   output logic                   busy,
   output logic [1:0]             dbg_state_o
);

   // One extra bit holds bytes+15 without overflow. The beat counter is wide
   // enough for every beat index.
   localparam int          CW         = max_bytes_w + 1;
   // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form.
   localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_AD   = 2'd2,
      S_DAT  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            lfsr_q, lfsr_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic [max_bytes_w-1:0] ad_bytes_q, d_bytes_q;
   logic                   enc_q;
   logic                   cfg_fire;

   // Beat datapath, shared by the AD and payload streams.
   logic [CW-1:0]          cur_bytes;
   logic [CW-1:0]          beats_m1;
   logic [4:0]             last_n;
   logic                   is_last;
   logic [15:0]            beat_keep;
   logic [31:0]            beat_idx;
   logic [127:0]           beat_raw;
   logic [127:0]           beat_data;

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return {1'b0, x[31:1]} ^ (x[0] ? LFSR_TAPS : 32'h0);
   endfunction

   always_comb begin
      cur_bytes = (state_q == S_AD) ? {1'b0, ad_bytes_q} : {1'b0, d_bytes_q};
      beats_m1  = ((cur_bytes + CW'(15)) >> 4) - CW'(1);
      is_last   = (cnt_q == beats_m1);
      // Valid bytes in the final beat. A zero remainder means the beat is full.
      last_n    = (cur_bytes[3:0] == 4'd0) ? 5'd16 : {1'b0, cur_bytes[3:0]};
      beat_keep = is_last ? (16'hFFFF << (5'd16 - last_n)) : 16'hFFFF;
      beat_idx  = 32'(cnt_q);
      beat_raw  = {lfsr_q, ~lfsr_q, lfsr_q ^ beat_idx, ~(lfsr_q ^ beat_idx)};
      beat_data = '0;
      for (int b = 0; b < 16; b++) begin
         beat_data[b*8 +: 8] = beat_keep[b] ? beat_raw[b*8 +: 8] : 8'h00;
      end
   end

   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      cfg_fire     = 1'b0;
      s_cfg_tready = 1'b0;
      m_cmd_tvalid = 1'b0;
      m_cmd_tdata  = '0;
      m_ad_tvalid  = 1'b0;
      m_ad_tlast   = 1'b0;
      m_ad_tdata   = '0;
      m_ad_tkeep   = '0;
      m_tvalid     = 1'b0;
      m_tlast      = 1'b0;
      m_tdata      = '0;
      m_tkeep      = '0;
      case (state_q)
         S_IDLE: begin
            s_cfg_tready = 1'b1;
            if (s_cfg_tvalid) begin
               cfg_fire = 1'b1;
               state_d  = S_CMD;
            end
         end
         S_CMD: begin
            m_cmd_tvalid = 1'b1;
            m_cmd_tdata  = {255'b0, enc_q, {4{~lfsr_q}}, {4{lfsr_q}}};
            if (m_cmd_tready) begin
               lfsr_d = lfsr_next(lfsr_q);
               cnt_d  = '0;
               if (ad_bytes_q != '0) begin
                  state_d = S_AD;
               end else if (d_bytes_q != '0) begin
                  state_d = S_DAT;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         S_AD: begin
            m_ad_tvalid = 1'b1;
            m_ad_tlast  = is_last;
            m_ad_tdata  = beat_data;
            m_ad_tkeep  = beat_keep;
            if (m_ad_tready) begin
               lfsr_d = lfsr_next(lfsr_q);
               if (is_last) begin
                  cnt_d = '0;
                  if (d_bytes_q != '0) begin
                     state_d = S_DAT;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_DAT: begin
            m_tvalid = 1'b1;
            m_tlast  = is_last;
            m_tdata  = beat_data;
            m_tkeep  = beat_keep;
            if (m_tready) begin
               lfsr_d = lfsr_next(lfsr_q);
               if (is_last) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         lfsr_q     <= lfsr_seed;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         ad_bytes_q <= '0;
         d_bytes_q  <= '0;
         enc_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         if (cfg_fire) begin
            ad_bytes_q <= s_cfg_ad_bytes;
            d_bytes_q  <= s_cfg_d_bytes;
            enc_q      <= s_cfg_encrypt;
         end
      end
   end

   assign done        = done_q;
   assign busy        = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axis_ascon_aead128_stimgen.sv
module tb_axis_ascon_aead128_stimgen;

   localparam logic [31:0] SEED = 32'hACE1_1234;
   // Expected/observed entry layout:
   //   [531] job_end, [530] last, [529:514] keep, [513:512] stream, [511:0] data
   // Streams: 0 = cmd, 1 = AD, 2 = payload.
   localparam int EW = 532;

   logic         clk;
   logic         resetn;
   logic         s_cfg_tvalid;
   logic         s_cfg_tready;
   logic [7:0]   s_cfg_ad_bytes;
   logic [7:0]   s_cfg_d_bytes;
   logic         s_cfg_encrypt;
   logic         m_cmd_tvalid;
   logic         m_cmd_tready;
   logic [511:0] m_cmd_tdata;
   logic         m_ad_tvalid;
   logic         m_ad_tready;
   logic         m_ad_tlast;
   logic [127:0] m_ad_tdata;
   logic [15:0]  m_ad_tkeep;
   logic         m_tvalid;
   logic         m_tready;
   logic         m_tlast;
   logic [127:0] m_tdata;
   logic [15:0]  m_tkeep;
   logic         done;
   logic         busy;
   logic [1:0]   dbg_state;

   axis_ascon_aead128_stimgen #(.lfsr_seed(SEED), .max_bytes_w(8)) dut (
      .clk(clk), .resetn(resetn),
      .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tready(s_cfg_tready),
      .s_cfg_ad_bytes(s_cfg_ad_bytes), .s_cfg_d_bytes(s_cfg_d_bytes),
      .s_cfg_encrypt(s_cfg_encrypt),
      .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready), .m_cmd_tdata(m_cmd_tdata),
      .m_ad_tvalid(m_ad_tvalid), .m_ad_tready(m_ad_tready), .m_ad_tlast(m_ad_tlast),
      .m_ad_tdata(m_ad_tdata), .m_ad_tkeep(m_ad_tkeep),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .done(done), .busy(busy), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;
   int unsigned stall_pct = 0;
   logic [EW-1:0]   exp_q[$];
   logic [EW-2:0]   obs_q[$];
   logic [EW-2:0]   run_a[$];
   logic [EW-2:0]   run_b[$];
   logic [31:0]     model_l = SEED;
   logic            busy_m  = 1'b0;
   logic            done_m  = 1'b0;
   logic            done_nx;
   int              acc_cnt  = 0;
   int              done_cnt = 0;
   logic [2:0]      vexp;
   logic [EW-2:0]   act;
   logic            rdy;
   logic [EW-1:0]   front;

   int          exp_s[5] = '{0, 1, 2, 2, 2};
   logic [15:0] exp_k[5] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000};
   logic        exp_t[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   int          jl_ad[4] = '{20, 0, 47, 130};
   int          jl_d[4]  = '{35, 17, 0, 64};

   task automatic cmp(input string name, input logic [EW-2:0] a, input logic [EW-2:0] e);
      n_cmp++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got timeout expected completion", name);
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [EW-1:0] mk(input int s, input logic [511:0] d,
                                        input logic [15:0] k, input logic l, input logic e);
      return {e, l, k, 2'(s), d};
   endfunction

   // Builds the full transfer list for a job, straight from the length rules.
   task automatic gen_job(input int ad, input int d, input logic enc);
      logic [31:0]  l;
      logic [15:0]  k;
      logic [127:0] raw;
      logic [127:0] bd;
      int           nbytes;
      int           nb;
      int           vb;
      logic         fin;
      l = model_l;
      exp_q.push_back(mk(0, {255'b0, enc, {4{~l}}, {4{l}}}, 16'h0, 1'b1, (ad == 0 && d == 0)));
      model_l = lfsr_next(model_l);
      for (int st = 1; st <= 2; st++) begin
         nbytes = (st == 1) ? ad : d;
         nb = (nbytes + 15) / 16;
         for (int i = 0; i < nb; i++) begin
            vb = (i == nb - 1) ? nbytes - 16 * i : 16;
            k = 16'h0;
            for (int b = 0; b < vb; b++) k[15 - b] = 1'b1;
            raw = {model_l, ~model_l, model_l ^ 32'(i), ~(model_l ^ 32'(i))};
            bd = '0;
            for (int b = 0; b < 16; b++) if (k[b]) bd[b*8 +: 8] = raw[b*8 +: 8];
            fin = (i == nb - 1) && (st == 2 || d == 0);
            exp_q.push_back(mk(st, {384'b0, bd}, k, (i == nb - 1), fin));
            model_l = lfsr_next(model_l);
         end
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!resetn) begin
         cmp("rst_valids", {m_cmd_tvalid, m_ad_tvalid, m_tvalid}, 0);
         cmp("rst_busy", busy, 0);
         cmp("rst_done", done, 0);
         cmp("rst_cfg_tready", s_cfg_tready, 1);
         exp_q.delete();
         busy_m  = 1'b0;
         done_m  = 1'b0;
         model_l = SEED;
      end else begin
         done_nx = 1'b0;
         cmp("cfg_tready", s_cfg_tready, !busy_m);
         cmp("busy", busy, busy_m);
         cmp("done", done, done_m);
         if (done) done_cnt++;
         vexp = 3'b000;
         if (busy_m && exp_q.size() > 0) begin
            front = exp_q[0];
            vexp  = 3'b100 >> front[513:512];
         end
         cmp("valids", {m_cmd_tvalid, m_ad_tvalid, m_tvalid}, vexp);
         if (vexp != 3'b000) begin
            case (front[513:512])
               2'd0: begin
                  act = {1'b1, 16'h0, 2'd0, m_cmd_tdata};
                  rdy = m_cmd_tready;
                  cmp("cmd_beat", act, front[EW-2:0]);
               end
               2'd1: begin
                  act = {m_ad_tlast, m_ad_tkeep, 2'd1, 384'b0, m_ad_tdata};
                  rdy = m_ad_tready;
                  cmp("ad_beat", act, front[EW-2:0]);
               end
               default: begin
                  act = {m_tlast, m_tkeep, 2'd2, 384'b0, m_tdata};
                  rdy = m_tready;
                  cmp("pay_beat", act, front[EW-2:0]);
               end
            endcase
            if (rdy) begin
               void'(exp_q.pop_front());
               obs_q.push_back(act);
               if (front[EW-1]) begin
                  busy_m  = 1'b0;
                  done_nx = 1'b1;
               end
            end
         end else if (!busy_m && s_cfg_tvalid) begin
            gen_job(int'(s_cfg_ad_bytes), int'(s_cfg_d_bytes), s_cfg_encrypt);
            busy_m = 1'b1;
            acc_cnt++;
         end
         done_m = done_nx;
      end
   end

   // ---------------- ready driver ----------------
   initial begin
      m_cmd_tready = 1'b1;
      m_ad_tready  = 1'b1;
      m_tready     = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_cmd_tready = ($urandom_range(99) >= stall_pct);
         m_ad_tready  = ($urandom_range(99) >= stall_pct);
         m_tready     = ($urandom_range(99) >= stall_pct);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      s_cfg_tvalid = 1'b0;
      @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      cmp("async_valids_low", {m_cmd_tvalid, m_ad_tvalid, m_tvalid}, 0);
      cmp("async_busy_low", busy, 0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2;
      resetn = 1'b1;
   endtask

   task automatic start_job(input int ad, input int d, input logic enc);
      logic ok;
      ok = 1'b0;
      @(posedge clk);
      #1;
      s_cfg_ad_bytes = 8'(ad);
      s_cfg_d_bytes  = 8'(d);
      s_cfg_encrypt  = enc;
      s_cfg_tvalid   = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (s_cfg_tready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("cfg_accept");
      @(posedge clk);
      #1;
      s_cfg_tvalid = 1'b0;
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (!busy_m && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("job_complete");
      repeat (2) @(negedge clk);
   endtask

   task automatic run_job(input int ad, input int d, input logic enc);
      obs_q.delete();
      start_job(ad, d, enc);
      wait_idle();
   endtask

   function automatic int count_pay();
      int c;
      c = 0;
      foreach (obs_q[i]) if (obs_q[i][513:512] == 2'd2) c++;
      return c;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      resetn         = 1'b0;
      s_cfg_tvalid   = 1'b0;
      s_cfg_ad_bytes = 8'd0;
      s_cfg_d_bytes  = 8'd0;
      s_cfg_encrypt  = 1'b0;
      stall_pct      = 0;
      do_reset();

      // Empty job: command only, key taken from the reset seed.
      run_job(0, 0, 1'b1);
      cmp("j1_count", obs_q.size(), 1);
      if (obs_q.size() >= 1) begin
         cmp("j1_key_lo", obs_q[0][31:0], 32'hACE1_1234);
         cmp("j1_key_hi", obs_q[0][127:96], 32'hACE1_1234);
         cmp("j1_nonce_lo", obs_q[0][159:128], 32'h531E_EDCB);
         cmp("j1_encrypt", obs_q[0][256], 1);
         cmp("j1_upper_zero", obs_q[0][511:257], 0);
      end

      // Second job: the LFSR has advanced exactly once.
      run_job(0, 0, 1'b0);
      if (obs_q.size() >= 1) begin
         cmp("j2_key_lo", obs_q[0][31:0], 32'h5670_891A);
         cmp("j2_encrypt", obs_q[0][256], 0);
      end

      // Five-byte AD job after reset.
      do_reset();
      run_job(5, 0, 1'b1);
      cmp("ad5_count", obs_q.size(), 2);
      if (obs_q.size() >= 2) begin
         cmp("ad5_keep", obs_q[1][529:514], 16'hF800);
         cmp("ad5_last", obs_q[1][530], 1);
         cmp("ad5_data", obs_q[1][127:0], 128'h5670891A_A9000000_00000000_00000000);
      end

      // ad=16, d=33: one full AD beat then three payload beats.
      run_job(16, 33, 1'b1);
      cmp("ad16_d33_count", obs_q.size(), 5);
      for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
         cmp("ad16_d33_stream", obs_q[i][513:512], exp_s[i]);
         cmp("ad16_d33_keep", obs_q[i][529:514], exp_k[i]);
         cmp("ad16_d33_last", obs_q[i][530], exp_t[i]);
      end

      // Same job list with and without backpressure must give the same beats.
      do_reset();
      stall_pct = 0;
      run_a.delete();
      for (int j = 0; j < 4; j++) begin
         run_job(jl_ad[j], jl_d[j], j[0]);
         foreach (obs_q[i]) run_a.push_back(obs_q[i]);
      end
      do_reset();
      stall_pct = 60;
      run_b.delete();
      for (int j = 0; j < 4; j++) begin
         run_job(jl_ad[j], jl_d[j], j[0]);
         foreach (obs_q[i]) run_b.push_back(obs_q[i]);
      end
      cmp("stall_seq_len", run_b.size(), run_a.size());
      for (int i = 0; i < run_a.size() && i < run_b.size(); i++) begin
         cmp("stall_seq_beat", run_b[i], run_a[i]);
      end

      // Random jobs under random backpressure.
      for (int j = 0; j < 20; j++) begin
         stall_pct = $urandom_range(0, 70);
         run_job(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of the payload stream.
      stall_pct = 0;
      obs_q.delete();
      start_job(0, 128, 1'b1);
      begin
         logic ok;
         ok = 1'b0;
         for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (count_pay() >= 2) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) timeout_fail("reach_dat_beat2");
      end
      do_reset();
      run_job(0, 0, 1'b1);
      if (obs_q.size() >= 1) begin
         cmp("post_rst_key_lo", obs_q[0][31:0], 32'hACE1_1234);
      end

      // Config valid held high: jobs accepted only when idle, one done each.
      stall_pct = 20;
      acc_cnt   = 0;
      done_cnt  = 0;
      @(posedge clk);
      #1;
      s_cfg_ad_bytes = 8'd3;
      s_cfg_d_bytes  = 8'd20;
      s_cfg_encrypt  = 1'b1;
      s_cfg_tvalid   = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      s_cfg_tvalid = 1'b0;
      wait_idle();
      cmp("held_done_per_job", done_cnt, acc_cnt);
      cmp("held_multi_accept", (acc_cnt >= 2), 1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_ascon_aead128_stimgen.md
AXIS_ASCON_AEAD128_STIMGEN -- requirements
Module: axis_ascon_aead128_stimgen

Interface
REQ-001 SHALL have parameter lfsr_seed, default 32'hACE1_1234: reset value of the 32-bit data LFSR; a seed of 0 is illegal.
REQ-002 SHALL have parameter max_bytes_w, default 8: width of the byte-length config fields.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have s_cfg_tvalid/s_cfg_tready, input/output, 1/1: job request handshake.
REQ-006 SHALL have s_cfg_ad_bytes/s_cfg_d_bytes, input, max_bytes_w each: AD and payload length in bytes.
REQ-007 SHALL have s_cfg_encrypt, input, 1: value placed in cmd bit 256 (1 = encrypt).
REQ-008 SHALL have m_cmd_tvalid/m_cmd_tready/m_cmd_tdata, out/in/out, 1/1/512: command stream.
REQ-009 SHALL have m_ad_tvalid/tready/tlast/tdata/tkeep, out/in/out/out/out, 1/1/1/128/16: AD stream.
REQ-010 SHALL have m_tvalid/tready/tlast/tdata/tkeep, out/in/out/out/out, 1/1/1/128/16: payload stream.
REQ-011 SHALL have done, output, 1: one-cycle pulse when a job's last transfer is accepted.
REQ-012 SHALL have busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CMD, AD, DAT; s_cfg_tready = (state == IDLE).
REQ-014 On an s_cfg handshake, SHALL latch both lengths and the encrypt flag and go to CMD on the next cycle.
REQ-015 In CMD, SHALL assert m_cmd_tvalid with tdata = {255'b0, encrypt, nonce[127:0], key[127:0]}.
REQ-016 key SHALL be {4{L}} and nonce {4{~L}}, where L is the LFSR value on entry to CMD.
REQ-017 On the cmd handshake, SHALL go to AD if ad_bytes != 0, else to DAT if d_bytes != 0, else to IDLE with done.
REQ-018 Beats per stream SHALL be ceil(bytes/16); on the last beat, tlast = 1 and tkeep has the top n bits set (keep[15:16-n]), with n = bytes mod 16, or 16 if that is 0.
REQ-019 Non-last beats SHALL have tkeep = 16'hFFFF and tlast = 0; tkeep SHALL never be 0 while tvalid.
REQ-020 Beat tdata SHALL be {L, ~L, L^beat_idx, ~(L^beat_idx)} (beat_idx zero-extended to 32 bits), with bytes whose keep bit is 0 driven to 0.
REQ-021 The LFSR (Galois, taps x^32+x^22+x^2+x+1) SHALL advance once per accepted cmd, AD or payload beat, and never otherwise.
REQ-022 After the last AD beat is accepted, SHALL go to DAT if d_bytes != 0, else to IDLE with done.
REQ-023 After the last payload beat is accepted, SHALL go to IDLE and pulse done in the cycle following acceptance.
REQ-024 Once tvalid is asserted on any master stream, SHALL hold tvalid and all payload signals stable until tready.
REQ-025 SHALL drive at most one master tvalid at a time; latency from cfg accept to m_cmd_tvalid SHALL be 1 cycle; consecutive beats SHALL be back-to-back under continuous tready.
REQ-026 The beat counter SHALL reset to 0 on entry to AD and on entry to DAT; the counter SHALL be wide enough for ceil(2^max_bytes_w/16) beats with no wrap.
REQ-027 s_cfg inputs arriving while busy SHALL be ignored (not accepted).

Reset
REQ-028 While resetn = 0, SHALL set the state to IDLE, all master tvalid to 0, done to 0, busy to 0, the LFSR to lfsr_seed and the counters to 0, regardless of the clock.
REQ-029 Deassertion of resetn mid-job SHALL abandon the job; the first cycle after deassertion SHALL show s_cfg_tready = 1 and no master tvalid.

Verification
REQ-030 cfg ad=0, d=0, encrypt=1, all tready=1 -> one cmd beat with bit256 = 1 and key[31:0] = lfsr_seed, done one cycle after the cmd handshake, no AD or payload beats.
REQ-031 cfg ad=16, d=33 -> 1 AD beat (tlast, keep FFFF); then 3 payload beats with keep FFFF, FFFF, 8000 and tlast only on the third.
REQ-032 cfg ad=5, d=0 -> a single AD beat with keep = F800, bytes 10..0 of tdata = 0, followed by done.
REQ-033 Random tready backpressure on all streams -> tvalid and data stable across stalls; the sequence is identical to the no-stall run with the same seed.
REQ-034 resetn pulled low during DAT beat 2 -> tvalid low asynchronously; after release, a new cfg yields cmd key[31:0] = lfsr_seed.
REQ-035 s_cfg_tvalid held high throughout -> a new job is accepted only in IDLE, and exactly one done pulse occurs per job.
